// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register file write port between two writeback sources,
// with registered write outputs and read-after-write forwarding hit flags.
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_addr,
    input  logic [DW-1:0] s0_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_addr,
    input  logic [DW-1:0] s1_data,
    input  logic          hold,
    output logic          we3,
    output logic [AW-1:0] a3,
    output logic [DW-1:0] wd3,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    output logic          fwd1_hit,
    output logic          fwd2_hit,
    output logic          last_grant
);
    logic en;
    always_comb begin
        en       = rst && !hold;
        s0_ready = en && s0_valid && (!s1_valid || last_grant);
        s1_ready = en && s1_valid && (!s0_valid || !last_grant);
        fwd1_hit = we3 && (a3 == a1) && (a1 != '0);
        fwd2_hit = we3 && (a3 == a2) && (a2 != '0);
    end
    // x0 writes still complete the handshake and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we3        <= 1'b0;
            a3         <= '0;
            wd3        <= '0;
            last_grant <= 1'b1;
        end else if (s0_ready) begin
            we3        <= (s0_addr != '0);
            a3         <= s0_addr;
            wd3        <= s0_data;
            last_grant <= 1'b0;
        end else if (s1_ready) begin
            we3        <= (s1_addr != '0);
            a3         <= s1_addr;
            wd3        <= s1_data;
            last_grant <= 1'b1;
        end else begin
            we3        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with hand-computed expectations for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0, hold = 1'b0;
    logic        s0_ready, s1_ready, we3, fwd1_hit, fwd2_hit, last_grant;
    logic [4:0]  s0_addr = '0, s1_addr = '0, a3, a1 = '0, a2 = '0;
    logic [31:0] s0_data = '0, s1_data = '0, wd3;
    int          tests = 0, fails = 0;

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .hold(hold), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, n1;
        logic g;
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h6;
        tick(); tick();
        check("rst_s0_ready", s0_ready, 0);
        check("rst_s1_ready", s1_ready, 0);
        check("rst_we3", we3, 0);
        check("rst_a3", a3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_last_grant", last_grant, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_s0_ready", s0_ready, 1);
        check("rel_s1_ready", s1_ready, 0);
        tick();
        s0_valid = 1'b0;
        check("w5_we3", we3, 1);
        check("w5_a3", a3, 5);
        check("w5_wd3", wd3, 32'h6);
        check("w5_lg", last_grant, 0);
        #1;
        check("w5_ready_drop", s0_ready, 0);
        tick();
        check("w5_we3_off", we3, 0);
        check("w5_a3_hold", a3, 5);
        check("w5_wd3_hold", wd3, 32'h6);

        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'hFF;
        #1;
        check("x0_s1_ready", s1_ready, 1);
        check("x0_s0_ready", s0_ready, 0);
        tick();
        s1_valid = 1'b0;
        check("x0_we3", we3, 0);
        check("x0_lg", last_grant, 1);
        check("x0_a3", a3, 0);
        check("x0_wd3", wd3, 32'hFF);

        n0 = 2; n1 = 2;
        s0_addr = 5'd1; s0_data = 32'h11; s1_addr = 5'd2; s1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            s0_valid = (n0 > 0);
            s1_valid = (n1 > 0);
            g = i[0];
            #1;
            check($sformatf("rr%0d_s0_ready", i), s0_ready, {31'd0, !g});
            check($sformatf("rr%0d_s1_ready", i), s1_ready, {31'd0, g});
            tick();
            if (g) n1--; else n0--;
            check($sformatf("rr%0d_we3", i), we3, 1);
            check($sformatf("rr%0d_a3", i), a3, g ? 2 : 1);
            check($sformatf("rr%0d_wd3", i), wd3, g ? 32'h22 : 32'h11);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
        check("rr_we3_off", we3, 0);

        hold = 1'b1; s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d_ready", i), s0_ready, 0);
            tick();
            check($sformatf("hold%0d_we3", i), we3, 0);
        end
        hold = 1'b0;
        #1;
        check("unhold_ready", s0_ready, 1);
        tick();
        check("unhold_we3", we3, 1);
        check("unhold_a3", a3, 7);
        check("unhold_lg", last_grant, 0);

        s0_addr = 5'd6; s0_data = 32'hA;
        #1;
        check("w6_ready", s0_ready, 1);
        tick();
        s0_valid = 1'b0; a1 = 5'd6; a2 = 5'd0;
        #1;
        check("fwd1_hit", fwd1_hit, 1);
        check("fwd2_miss", fwd2_hit, 0);
        check("fwd_wd3", wd3, 32'hA);
        a2 = 5'd6;
        #1;
        check("fwd2_both", fwd2_hit, 1);
        a2 = 5'd3;
        #1;
        check("fwd2_other", fwd2_hit, 0);
        a2 = 5'd0;
        rst = 1'b0;
        #1;
        check("arst_we3", we3, 0);
        check("arst_fwd1", fwd1_hit, 0);
        check("arst_wd3", wd3, 0);
        check("arst_lg", last_grant, 1);
        tick();
        rst = 1'b1;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
